// File: rtl/pc_sequencer.sv
// Program-counter and run-control sequencer.
// Owns the host-writable branch-target LUT.
module pc_sequencer #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              LOAD_LAT   = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [1:0]      Branch,
  input  logic [3:0]      targetLUT,
  input  logic            loadMem,
  input  logic            halt,
  input  logic            sc_flag,
  input  logic            lut_we,
  input  logic [3:0]      lut_addr,
  input  logic [PC_W-1:0] lut_data,
  output logic [PC_W-1:0] PC,
  output logic            exec_en,
  output logic            branch_taken,
  output logic            Ack
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL,
    DONE
  } state_t;

  localparam bit HAS_STALL = (LOAD_LAT > 0);
  localparam logic [2:0] STALL_INIT =
    HAS_STALL ? 3'(LOAD_LAT - 1) : 3'd0;

  state_t          state;
  logic [2:0]      cnt;
  logic [PC_W-1:0] lut [16];
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic            taken;

  assign target  = lut[targetLUT];
  assign pc_inc  = PC + PC_W'(1);
  assign exec_en = (state == RUN);
  assign branch_taken = exec_en & taken & ~halt;

  // Branch condition decode against the status flag
  always_comb begin
    taken = 1'b0;
    case (Branch)
      2'b01:   taken = sc_flag;
      2'b10:   taken = ~sc_flag;
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Branch-target table; reads see the old entry during a write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_addr] <= lut_data;
    end
  end

  // Run-control FSM with PC, stall counter and Ack
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      PC    <= START_ADDR;
      cnt   <= '0;
      Ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            PC    <= START_ADDR;
            state <= RUN;
          end
        end
        RUN: begin
          if (halt) begin
            state <= DONE;
            Ack   <= 1'b1;
          end else if (taken) begin
            PC <= target;
          end else if (loadMem && HAS_STALL) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end else begin
            PC <= pc_inc;
          end
        end
        STALL: begin
          if (cnt == 3'd0) begin
            PC    <= pc_inc;
            state <= RUN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          if (!Start) begin
            state <= IDLE;
            Ack   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
